led_strip_serializer: RTL and testbench

LED_STRIP_SERIALIZER -- requirements
Module: led_strip_serializer

---
 rtl/led_pkg.sv | 23 ++
 rtl/led_pixel_scale.sv | 14 +
 rtl/led_strip_serializer.sv | 133 +++++++++++++
 tb/tb_led_strip_serializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED strip serializer.
package led_pkg;

  localparam int NUM_LEDS = 10;
  localparam int COLOR_W  = 24;

  typedef logic [COLOR_W-1:0] pixel_t;
  typedef pixel_t [NUM_LEDS-1:0] strip_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } state_t;

  // Scale one 8-bit channel by (brightness+1)/8, truncating.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [2:0] b);
    logic [10:0] prod;
    prod = 11'(c) * (11'(b) + 11'd1);
    return prod[10:3];
  endfunction

endpackage

// File: rtl/led_pixel_scale.sv
// Applies the global brightness level to the three channels of one pixel.
module led_pixel_scale
  import led_pkg::*;
(
  input  pixel_t     pixel,
  input  logic [2:0] brightness,
  output pixel_t     scaled
);

  assign scaled = {scale_chan(pixel[23:16], brightness),
                   scale_chan(pixel[15:8],  brightness),
                   scale_chan(pixel[7:0],   brightness)};

endmodule

// File: rtl/led_strip_serializer.sv
// Captures a brightness-scaled frame and shifts it out as WS281x-style
// pulse-width coded bits, followed by a low latch period.
module led_strip_serializer #(
  parameter int NUM_LEDS = led_pkg::NUM_LEDS,
  parameter int T0H      = 4,
  parameter int T1H      = 8,
  parameter int TBIT     = 12,
  parameter int TRST     = 50
) (
  input  logic                           clk,
  input  logic                           rst,
  input  led_pkg::pixel_t [NUM_LEDS-1:0] strip,
  input  logic [2:0]                     brightness,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  output logic                           dout,
  output logic                           busy,
  output logic                           frame_done
);

  import led_pkg::*;

  localparam int CYC_W = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAT_W = (TRST > 1) ? $clog2(TRST) : 1;
  localparam logic [4:0] BIT_MSB = 5'(COLOR_W - 1);

  if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TRST >= 1)) begin : g_bad_timing
    $error("led_strip_serializer: timing needs 1 <= T0H < T1H < TBIT and TRST >= 1");
  end

  state_t                    state_q, state_d;
  logic [CYC_W-1:0]          cyc_q;
  logic [4:0]                bit_q;
  logic [PIX_W-1:0]          pix_q;
  logic [LAT_W-1:0]          lat_q;
  logic                      done_q;
  pixel_t [NUM_LEDS-1:0]     buf_q;
  pixel_t [NUM_LEDS-1:0]     scaled;

  logic accept, bit_end, frame_end, latch_end, cur_bit;

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_scale
    led_pixel_scale u_scale (
      .pixel      (strip[g]),
      .brightness (brightness),
      .scaled     (scaled[g])
    );
  end

  assign cur_bit    = buf_q[pix_q][bit_q];
  assign bit_end    = (cyc_q == CYC_W'(TBIT - 1));
  assign frame_end  = bit_end && (bit_q == 5'd0) && (pix_q == PIX_W'(NUM_LEDS - 1));
  assign latch_end  = (lat_q == LAT_W'(TRST - 1));
  assign frame_done = done_q;

  // Next-state decode and Moore-style outputs from the registered state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d     = state_q;
    accept      = 1'b0;
    frame_ready = 1'b0;
    busy        = 1'b0;
    dout        = 1'b0;
    case (state_q)
      IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        dout = (cyc_q < (cur_bit ? CYC_W'(T1H) : CYC_W'(T0H)));
        if (frame_end) state_d = LATCH;
      end
      LATCH: begin
        busy = 1'b1;
        if (latch_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, bit/pixel/latch counters and the frame buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      // NOTE: the frame buffer is cleared as well, so an aborted frame
      // leaves no stale pixel data behind.
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == LATCH) && latch_end;
      case (state_q)
        IDLE: begin
          if (accept) begin
            buf_q <= scaled;
            cyc_q <= '0;
            bit_q <= BIT_MSB;
            pix_q <= '0;
            lat_q <= '0;
          end
        end
        SEND: begin
          lat_q <= '0;
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == 5'd0) begin
              bit_q <= BIT_MSB;
              pix_q <= frame_end ? '0 : pix_q + 1'b1;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        LATCH: lat_q <= latch_end ? '0 : lat_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_serializer.sv
// Directed bench for led_strip_serializer: decodes the pulse widths on dout
// back into pixels and compares them with hand-computed values.
module tb_led_strip_serializer;

  import led_pkg::*;

  localparam int NL        = 10;
  localparam int T0H       = 4;
  localparam int T1H       = 8;
  localparam int TBIT      = 12;
  localparam int TRST      = 50;
  localparam int SEND_CYC  = 24 * NL * TBIT;   // 2880
  localparam int FRAME_CYC = SEND_CYC + TRST;  // 2930

  logic       clk = 1'b0;
  logic       rst;
  strip_t     strip;
  logic [2:0] brightness;
  logic       frame_valid;
  logic       frame_ready, dout, busy, frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int hi_len[24];
  int lo_len[24];

  led_strip_serializer #(
    .NUM_LEDS (NL), .T0H (T0H), .T1H (T1H), .TBIT (TBIT), .TRST (TRST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .strip       (strip),
    .brightness  (brightness),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic strip_t fill(input pixel_t p);
    strip_t s;
    for (int i = 0; i < NL; i++) s[i] = p;
    return s;
  endfunction

  // Called at the falling edge inside the first cycle of a pixel; returns at
  // the falling edge of the first cycle after it.
  task automatic rx_pixel(output pixel_t px, inout int bad);
    int   hi, lo;
    logic seen_low;
    px = '0;
    for (int b = 0; b < 24; b++) begin
      hi = 0; lo = 0; seen_low = 1'b0;
      for (int c = 0; c < TBIT; c++) begin
        if (dout === 1'b1) begin
          hi++;
          if (seen_low) bad++;
        end else begin
          lo++;
          seen_low = 1'b1;
        end
        if (busy !== 1'b1) bad++;
        @(negedge clk);
      end
      hi_len[b] = hi;
      lo_len[b] = lo;
      if (hi == T1H) px[23-b] = 1'b1;
      else if (hi != T0H) bad++;
    end
  endtask

  task automatic rx_frame(input string tag, input strip_t exp);
    pixel_t px;
    int     bad;
    bad = 0;
    for (int p = 0; p < NL; p++) begin
      rx_pixel(px, bad);
      check($sformatf("%s pixel%0d", tag, p), px, exp[p]);
    end
    check({tag, " malformed bits"}, bad, 0);
  endtask

  // Called at cycle SEND_CYC after acceptance; returns in the frame_done cycle.
  task automatic wait_done(input string tag);
    int k, latch_hi;
    k = SEND_CYC;
    latch_hi = 0;
    while (frame_done !== 1'b1 && k < FRAME_CYC + 100) begin
      if (dout !== 1'b0) latch_hi++;
      @(negedge clk);
      k++;
    end
    check({tag, " done cycle"}, k, FRAME_CYC);
    check({tag, " latch dout high"}, latch_hi, 0);
    check({tag, " ready at done"}, frame_ready, 1'b1);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " dout at done"}, dout, 1'b0);
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge of cycle 0.
  task automatic accept(input string tag, input strip_t s, input logic [2:0] b);
    strip       = s;
    brightness  = b;
    frame_valid = 1'b1;
    check({tag, " ready before accept"}, frame_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    check({tag, " dout first cycle"}, dout, 1'b1);
    check({tag, " busy first cycle"}, busy, 1'b1);
  endtask

  strip_t pat;
  int     dn, bz;

  initial begin
    // Distinct pixels; brightness 7 is the identity scale (c*8>>3 = c).
    for (int i = 0; i < NL; i++)
      pat[i] = {8'(8'h11 * (i + 1)), 8'(8'hA0 + i), 8'(8'h0F ^ i)};

    // Reset with frame_valid high at the same time: reset must win.
    rst = 1'b1; frame_valid = 1'b1; brightness = 3'd7; strip = fill(24'hFF0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dout", dout, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset ready", frame_ready, 1'b1);
    check("reset done", frame_done, 1'b0);
    rst = 1'b0; frame_valid = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 1'b0);
    check("idle dout", dout, 1'b0);

    // Red frame at full brightness: 1-bits are 8 high/4 low, 0-bits 4 high/8 low.
    accept("red", fill(24'hFF0000), 3'd7);
    rx_frame("red", fill(24'hFF0000));
    check("red bit0 high", hi_len[0], T1H);
    check("red bit0 low", lo_len[0], TBIT - T1H);
    check("red bit7 high", hi_len[7], T1H);
    check("red bit8 high", hi_len[8], T0H);
    check("red bit8 low", lo_len[8], TBIT - T0H);
    wait_done("red");

    // Scaling: 0xFF8040 at brightness 0 -> FF*1>>3=1F, 80*1>>3=10, 40*1>>3=08.
    accept("scale0", fill(24'hFF8040), 3'd0);
    rx_frame("scale0", fill(24'h1F1008));
    wait_done("scale0");

    // Brightness 3 -> FF*4>>3=7F, 80*4>>3=40, 40*4>>3=20.
    accept("scale3", fill(24'hFF8040), 3'd3);
    rx_frame("scale3", fill(24'h7F4020));
    wait_done("scale3");

    // Input isolation: inputs change right after capture.
    accept("iso", pat, 3'd7);
    strip = fill(24'h0000FF);
    brightness = 3'd0;
    rx_frame("iso", pat);
    wait_done("iso");

    // Back-to-back: frame_valid held high across the frame_done cycle.
    strip = fill(24'h00FF00); brightness = 3'd7; frame_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b1 dout first cycle", dout, 1'b1);
    rx_frame("b2b1", fill(24'h00FF00));
    wait_done("b2b1");
    check("b2b valid at done", frame_valid, 1'b1);
    strip = pat;
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    check("b2b2 dout after done", dout, 1'b1);
    check("b2b2 busy after done", busy, 1'b1);
    check("b2b2 done cleared", frame_done, 1'b0);
    rx_frame("b2b2", pat);
    wait_done("b2b2");

    // Reset during bit 100 aborts the frame.
    accept("abort", pat, 3'd7);
    repeat (100 * TBIT + 3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort dout", dout, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort ready", frame_ready, 1'b1);
    check("abort done", frame_done, 1'b0);
    dn = 0; bz = 0;
    for (int i = 0; i < FRAME_CYC + 70; i++) begin
      if (frame_done !== 1'b0) dn++;
      if (busy !== 1'b0) bz++;
      @(negedge clk);
    end
    check("abort no frame_done", dn, 0);
    check("abort stays idle", bz, 0);

    // Fresh frame after the abort.
    accept("fresh", fill(24'h123456), 3'd7);
    rx_frame("fresh", fill(24'h123456));
    wait_done("fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
